// File: rtl/fetch_sequencer.sv
//==============================================================================
// Module      : fetch_sequencer
// Description : Fetch stage: loads PC from the reset vector, fetches words,
//               merges LDM opcode+immediate, applies stall/jump redirect.
//               Optional interrupt redirect when FETCH_IRQ_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RST_VEC_ADDR = '0,
    parameter logic [4:0]        LDM_OPCODE   = 5'b10100,
    parameter logic [ADDR_W-1:0] IRQ_VEC      = ADDR_W'(2)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_cs,
    input  logic [15:0]       mem_rdata,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              ifid_valid,
    output logic [15:0]       ifid_instr,
    output logic [15:0]       ifid_imm,
    output logic [ADDR_W-1:0] ifid_npc
`ifdef FETCH_IRQ_EN
    ,
    input  logic              irq,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] epc
`endif
);

    typedef enum logic [1:0] {
        ST_RST_HI = 2'd0,
        ST_RST_LO = 2'd1,
        ST_RUN    = 2'd2,
        ST_IMM    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [15:0]       r_held;
    logic [15:0]       w_held_nxt;
    logic              r_ifid_valid;
    logic              w_ifid_valid_nxt;
    logic [15:0]       r_ifid_instr;
    logic [15:0]       w_ifid_instr_nxt;
    logic [15:0]       r_ifid_imm;
    logic [15:0]       w_ifid_imm_nxt;
    logic [ADDR_W-1:0] r_ifid_npc;
    logic [ADDR_W-1:0] w_ifid_npc_nxt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [31:0]       w_pc32;
    logic              w_irq_take;

    assign w_pc_inc = r_pc + c_one;
    assign w_pc32   = 32'(r_pc);

`ifdef FETCH_IRQ_EN
    logic [ADDR_W-1:0] r_epc;

    // Interrupts are only taken on an unstalled RUN cycle so an LDM pair is never split.
    assign w_irq_take = !rst && (r_state == ST_RUN) && irq && !jump_en && !stall;
    assign irq_ack    = w_irq_take;
    assign epc        = r_epc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_epc <= '0;
        end else if (w_irq_take) begin
            r_epc <= r_pc;
        end
    end
`else
    assign w_irq_take = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_held_nxt       = r_held;
        w_ifid_valid_nxt = r_ifid_valid;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_imm_nxt   = r_ifid_imm;
        w_ifid_npc_nxt   = r_ifid_npc;
        w_mem_addr       = r_pc;
        case (r_state)
            ST_RST_HI: begin
                w_mem_addr       = RST_VEC_ADDR;
                w_pc_nxt         = ADDR_W'({mem_rdata, w_pc32[15:0]});
                w_ifid_valid_nxt = 1'b0;
                w_state_nxt      = ST_RST_LO;
            end
            ST_RST_LO: begin
                w_mem_addr       = RST_VEC_ADDR + c_one;
                w_pc_nxt         = ADDR_W'({w_pc32[31:16], mem_rdata});
                w_ifid_valid_nxt = 1'b0;
                w_state_nxt      = ST_RUN;
            end
            default: begin
                if (jump_en) begin
                    // A pending LDM is abandoned; its held word is simply never emitted.
                    w_pc_nxt         = jump_addr;
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_instr_nxt = '0;
                    w_ifid_imm_nxt   = '0;
                    w_state_nxt      = ST_RUN;
                end else if (w_irq_take) begin
                    w_pc_nxt         = IRQ_VEC;
                    w_ifid_valid_nxt = 1'b0;
                end else if (!stall) begin
                    w_pc_nxt = w_pc_inc;
                    if (r_state == ST_IMM) begin
                        w_ifid_instr_nxt = r_held;
                        w_ifid_imm_nxt   = mem_rdata;
                        w_ifid_npc_nxt   = w_pc_inc;
                        w_ifid_valid_nxt = 1'b1;
                        w_state_nxt      = ST_RUN;
                    end else if (mem_rdata[15:11] == LDM_OPCODE) begin
                        w_held_nxt       = mem_rdata;
                        w_ifid_valid_nxt = 1'b0;
                        w_state_nxt      = ST_IMM;
                    end else begin
                        w_ifid_instr_nxt = mem_rdata;
                        w_ifid_imm_nxt   = '0;
                        w_ifid_npc_nxt   = w_pc_inc;
                        w_ifid_valid_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RST_HI;
            r_pc         <= '0;
            r_held       <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_imm   <= '0;
            r_ifid_npc   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_held       <= w_held_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_imm   <= w_ifid_imm_nxt;
            r_ifid_npc   <= w_ifid_npc_nxt;
        end
    end

    assign mem_addr   = w_mem_addr;
    assign mem_cs     = !rst;
    assign pc         = r_pc;
    assign ifid_valid = r_ifid_valid;
    assign ifid_instr = r_ifid_instr;
    assign ifid_imm   = r_ifid_imm;
    assign ifid_npc   = r_ifid_npc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
//==============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer: directed scenarios
//               plus randomized program/stall/jump traffic vs. a reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        irq;
    logic [31:0] mem_addr;
    logic        mem_cs;
    logic [15:0] mem_rdata;
    logic [31:0] pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_imm;
    logic [31:0] ifid_npc;
`ifdef FETCH_IRQ_EN
    logic        irq_ack;
    logic [31:0] epc;
    localparam bit c_irq_on = 1'b1;
`else
    localparam bit c_irq_on = 1'b0;
`endif

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_cs     (mem_cs),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_imm   (ifid_imm),
        .ifid_npc   (ifid_npc)
`ifdef FETCH_IRQ_EN
        ,
        .irq        (irq),
        .irq_ack    (irq_ack),
        .epc        (epc)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: phase 0/1 = reading vector words, 2 = fetching, 3 = awaiting LDM immediate.
    int          m_phase = 0;
    logic [31:0] m_pc    = '0;
    logic [15:0] m_held  = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_instr = '0;
    logic [15:0] m_imm   = '0;
    logic [31:0] m_npc   = '0;
    logic [31:0] m_epc   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic j,
                        input logic [31:0] ja, input logic q);
        logic [31:0] a;
        logic [15:0] w;
        logic        ack;
        rst = r; stall = s; jump_en = j; jump_addr = ja; irq = q;
        #1;
        a   = (m_phase == 0) ? 32'h0 : (m_phase == 1) ? 32'h1 : m_pc;
        w   = mem[a[7:0]];
        ack = c_irq_on && !r && (m_phase == 2) && q && !j && !s;
        if (!r) check("mem_addr", mem_addr, a);
        check("mem_cs", 32'(mem_cs), 32'(!r));
`ifdef FETCH_IRQ_EN
        check("irq_ack", 32'(irq_ack), 32'(ack));
`endif
        if (r) begin
            m_phase = 0; m_pc = '0; m_held = '0; m_valid = 1'b0;
            m_instr = '0; m_imm = '0; m_npc = '0; m_epc = '0;
        end else if (m_phase == 0) begin
            m_pc = {w, m_pc[15:0]}; m_valid = 1'b0; m_phase = 1;
        end else if (m_phase == 1) begin
            m_pc = {m_pc[31:16], w}; m_valid = 1'b0; m_phase = 2;
        end else if (j) begin
            m_pc = ja; m_valid = 1'b0; m_instr = '0; m_imm = '0; m_phase = 2;
        end else if (ack) begin
            m_epc = m_pc; m_pc = 32'h2; m_valid = 1'b0;
        end else if (!s) begin
            if (m_phase == 3) begin
                m_instr = m_held; m_imm = w; m_npc = m_pc + 1; m_valid = 1'b1; m_phase = 2;
            end else if (w[15:11] == 5'b10100) begin
                m_held = w; m_valid = 1'b0; m_phase = 3;
            end else begin
                m_instr = w; m_imm = '0; m_npc = m_pc + 1; m_valid = 1'b1;
            end
            m_pc = m_pc + 1;
        end
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        check("ifid_instr", 32'(ifid_instr), 32'(m_instr));
        check("ifid_imm", 32'(ifid_imm), 32'(m_imm));
        check("ifid_npc", ifid_npc, m_npc);
`ifdef FETCH_IRQ_EN
        check("epc", epc, m_epc);
`endif
        @(negedge clk);
    endtask

    task automatic go(input logic s);
        step(1'b0, s, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic boot(input logic [15:0] hi, input logic [15:0] lo);
        mem[0] = hi;
        mem[1] = lo;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        go(1'b0);
        go(1'b0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = '0; irq = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        @(negedge clk);

        // Reset vector and straight-line fetch
        mem[8'h20] = 16'h0841; mem[8'h21] = 16'h1062; mem[8'h22] = 16'h0000;
        boot(16'h0000, 16'h0020);
        check("vec_pc", pc, 32'h20);
        check("vec_valid", 32'(ifid_valid), 32'h0);
        go(1'b0);
        check("sl0_instr", 32'(ifid_instr), 32'h0841);
        check("sl0_npc", ifid_npc, 32'h21);
        go(1'b0);
        check("sl1_instr", 32'(ifid_instr), 32'h1062);
        check("sl1_npc", ifid_npc, 32'h22);
        go(1'b0);
        check("sl2_instr", 32'(ifid_instr), 32'h0000);
        check("sl2_npc", ifid_npc, 32'h23);

        // LDM merge
        mem[8'h20] = 16'hA0E0; mem[8'h21] = 16'h1234; mem[8'h40] = 16'h1062;
        boot(16'h0000, 16'h0020);
        go(1'b0);
        check("ldm_bubble", 32'(ifid_valid), 32'h0);
        go(1'b0);
        check("ldm_instr", 32'(ifid_instr), 32'hA0E0);
        check("ldm_imm", 32'(ifid_imm), 32'h1234);
        check("ldm_npc", ifid_npc, 32'h22);
        check("ldm_pc", pc, 32'h22);

        // Jump during the immediate cycle
        boot(16'h0000, 16'h0020);
        go(1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        check("jimm_valid", 32'(ifid_valid), 32'h0);
        check("jimm_pc", pc, 32'h40);
        go(1'b0);
        check("jimm_instr", 32'(ifid_instr), 32'h1062);
        check("jimm_npc", ifid_npc, 32'h41);

        // Stall then jump while stalled
        mem[8'h25] = 16'h0841;
        boot(16'h0000, 16'h0025);
        go(1'b1);
        go(1'b1);
        check("stall_pc", pc, 32'h25);
        step(1'b0, 1'b1, 1'b1, 32'h30, 1'b0);
        check("stall_jump_pc", pc, 32'h30);

        // Wrap at all-ones
        mem[8'hFF] = 16'h0841;
        boot(16'hFFFF, 16'hFFFF);
        check("wrap_start", pc, 32'hFFFF_FFFF);
        go(1'b0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_npc", ifid_npc, 32'h0);

`ifdef FETCH_IRQ_EN
        mem[8'h30] = 16'h0841;
        boot(16'h0000, 16'h0030);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("irq_epc", epc, 32'h30);
        check("irq_pc", pc, 32'h2);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`endif

        // Randomized program and control traffic
        for (int i = 2; i < 256; i++) begin
            if ($urandom_range(3) == 0) mem[i] = {5'b10100, 11'($urandom)};
            else                        mem[i] = 16'($urandom);
        end
        boot(16'h0000, 16'($urandom_range(255)));
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(199) == 0) begin
                step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            end else begin
                step(1'b0, ($urandom_range(3) == 0), ($urandom_range(19) == 0),
                     ($urandom_range(15) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(255)),
                     c_irq_on && ($urandom_range(9) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
